// File: rtl/mac_input_fifo_writer_pkg.sv
// Shared types and defaults for the multiplier input path.
// Used by the input FIFO writer and the multiplier FSM.
package mac_input_fifo_writer_pkg;

   localparam int MULT_DATA_W = 32;
   localparam int MULT_NCOEF  = 8;

   typedef enum logic {LOAD_COEF = 1'b0, STREAM = 1'b1} ld_state_t;

endpackage

// File: rtl/mac_input_fifo_writer_if.sv
// Bus between the input pins / multiplier_fsm and the input FIFO writer.
// The writer uses the slave modport; its environment uses the master modport.
interface mac_input_fifo_writer_if
   import mac_input_fifo_writer_pkg::*;
#(
   parameter int DATA_W = MULT_DATA_W,
   parameter int NCOEF  = MULT_NCOEF
);

   logic                    PushIn;
   logic [DATA_W-1:0]       DataIn;
   logic                    PushCoef;
   logic [DATA_W-1:0]       CoefIn;
   logic                    StopIn;
   logic                    fifoPullOut;
   logic                    fifo_empty;
   logic [DATA_W-1:0]       fifo_dout;
   logic [NCOEF*DATA_W-1:0] coef_bank;
   logic                    coef_valid;
   logic                    ovf_err;
   logic                    unf_err;

   modport slave (
      input  PushIn, DataIn, PushCoef, CoefIn, fifoPullOut,
      output StopIn, fifo_empty, fifo_dout, coef_bank, coef_valid, ovf_err, unf_err
   );

   modport master (
      output PushIn, DataIn, PushCoef, CoefIn, fifoPullOut,
      input  StopIn, fifo_empty, fifo_dout, coef_bank, coef_valid, ovf_err, unf_err
   );

endinterface

// File: rtl/mac_input_fifo_writer_fifo.sv
// First-word-fall-through sample FIFO with sticky overflow/underflow flags.
// 'hold' masks the FIFO as empty to the consumer without touching its contents.
module mac_input_fifo_writer_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [DATA_W-1:0]       din,
   input  logic                    pullReq,
   input  logic                    hold,
   output logic [DATA_W-1:0]       dout,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  nextCount,
   output logic                    ovfErr,
   output logic                    unfErr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W:0]    count;
   logic              full;
   logic              pop;
   logic              accept;

   assign empty  = (count == '0) | hold;
   assign full   = (count == FULL_CNT);
   assign pop    = pullReq & ~empty;
   // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
   assign accept = push & (~full | pop);

   always_comb begin
      nextCount = count;
      if (accept && !pop) nextCount = count + (PTR_W+1)'(1);
      if (pop && !accept) nextCount = count - (PTR_W+1)'(1);
   end

   // Empty FIFO presents zero rather than stale storage.
   assign dout = (count == '0) ? '0 : mem[rdPtr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         count  <= '0;
         ovfErr <= 1'b0;
         unfErr <= 1'b0;
      end else begin
         if (accept) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)    rdPtr <= rdPtr + PTR_W'(1);
         count <= nextCount;
         if (push && full && !pop) ovfErr <= 1'b1;
         if (pullReq && empty)     unfErr <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wrPtr] <= din;
   end

endmodule

// File: rtl/mac_input_fifo_writer.sv
// Producer side of the multiplier input FIFO: coefficient bank loader FSM,
// sample FIFO, almost-full backpressure and empty gating for multiplier_fsm.
module mac_input_fifo_writer
   import mac_input_fifo_writer_pkg::*;
#(
   parameter int DATA_W = MULT_DATA_W,
   parameter int DEPTH  = 16,
   parameter int NCOEF  = MULT_NCOEF,
   parameter int AF_LVL = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   mac_input_fifo_writer_if.slave bus
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CIDX_W = $clog2(NCOEF);
   localparam logic [0:0]        ST_LOAD   = LOAD_COEF;
   localparam logic [0:0]        ST_STREAM = STREAM;
   localparam logic [CIDX_W-1:0] LAST_IDX  = CIDX_W'(NCOEF-1);
   localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]    AF_CNT    = (PTR_W+1)'(AF_LVL);

   logic [0:0]              state;
   logic [CIDX_W-1:0]       coefCnt;
   logic [CIDX_W-1:0]       wrIdx;
   logic [NCOEF*DATA_W-1:0] coefBank;
   logic                    coefValid;
   logic                    stopIn;
   logic [PTR_W:0]          nextCount;

   assign coefValid = (state == ST_STREAM);
   // A coefficient arriving while streaming restarts the set at index 0.
   assign wrIdx = coefValid ? '0 : coefCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_LOAD;
         coefCnt <= '0;
      end else if (bus.PushCoef) begin
         if (state == ST_STREAM) begin
            state   <= ST_LOAD;
            coefCnt <= CIDX_W'(1);
         end else if (coefCnt == LAST_IDX) begin
            state   <= ST_STREAM;
            coefCnt <= '0;
         end else begin
            coefCnt <= coefCnt + CIDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coefBank <= '0;
      end else if (bus.PushCoef) begin
         for (int k = 0; k < NCOEF; k++) begin
            if (wrIdx == CIDX_W'(k)) coefBank[k*DATA_W +: DATA_W] <= bus.CoefIn;
         end
      end
   end

   // Registered from the post-update count; AF_LVL covers the source's one-cycle reaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stopIn <= 1'b0;
      else       stopIn <= ((FULL_CNT - nextCount) <= AF_CNT);
   end

   mac_input_fifo_writer_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) uFifo (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.PushIn),
      .din       (bus.DataIn),
      .pullReq   (bus.fifoPullOut),
      .hold      (~coefValid),
      .dout      (bus.fifo_dout),
      .empty     (bus.fifo_empty),
      .nextCount (nextCount),
      .ovfErr    (bus.ovf_err),
      .unfErr    (bus.unf_err)
   );

   assign bus.StopIn     = stopIn;
   assign bus.coef_bank  = coefBank;
   assign bus.coef_valid = coefValid;

endmodule

// File: tb/tb_mac_input_fifo_writer.sv
// Bench for mac_input_fifo_writer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mac_input_fifo_writer;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int NC    = 8;
   localparam int AF    = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mac_input_fifo_writer_if #(.DATA_W(DW), .NCOEF(NC)) bus ();

   mac_input_fifo_writer #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .NCOEF  (NC),
      .AF_LVL (AF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int passCnt = 0;
   int totalCnt = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      totalCnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passCnt++;
   endtask

   // Reference model: sample queue plus coefficient set bookkeeping.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] mc [NC];
   int  mLoaded = 0;
   bit  mStream = 0, mOvf = 0, mUnf = 0, mStop = 0;
   bit  mEmpty, mPop, mAcc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         for (int k = 0; k < NC; k++) mc[k] = '0;
         mLoaded = 0; mStream = 0; mOvf = 0; mUnf = 0; mStop = 0;
      end else begin
         mEmpty = (mq.size() == 0) || !mStream;
         mPop   = bus.fifoPullOut && !mEmpty;
         mAcc   = bus.PushIn && ((mq.size() < DEPTH) || mPop);
         if (bus.PushIn && !mAcc) mOvf = 1;
         if (bus.fifoPullOut && mEmpty) mUnf = 1;
         if (mPop) void'(mq.pop_front());
         if (mAcc) mq.push_back(bus.DataIn);
         mStop = (DEPTH - mq.size()) <= AF;
         if (bus.PushCoef) begin
            if (mStream) begin
               mc[0] = bus.CoefIn; mLoaded = 1; mStream = 0;
            end else begin
               mc[mLoaded] = bus.CoefIn;
               mLoaded++;
               if (mLoaded == NC) begin mStream = 1; mLoaded = 0; end
            end
         end
      end
   end

   logic [NC*DW-1:0] expBank;
   always @(negedge clk) begin
      for (int k = 0; k < NC; k++) expBank[k*DW +: DW] = mc[k];
      check("coef_valid", 256'(bus.coef_valid), 256'(mStream));
      check("fifo_empty", 256'(bus.fifo_empty), 256'((mq.size() == 0) || !mStream));
      check("fifo_dout",  256'(bus.fifo_dout),  256'((mq.size() == 0) ? '0 : mq[0]));
      check("coef_bank",  256'(bus.coef_bank),  256'(expBank));
      check("StopIn",     256'(bus.StopIn),     256'(mStop));
      check("ovf_err",    256'(bus.ovf_err),    256'(mOvf));
      check("unf_err",    256'(bus.unf_err),    256'(mUnf));
   end

   // Apply one cycle of inputs; returns 2 time units after the capturing edge.
   task automatic drive(input bit p, input logic [DW-1:0] d, input bit pc,
                        input logic [DW-1:0] c, input bit pl);
      bus.PushIn = p; bus.DataIn = d; bus.PushCoef = pc; bus.CoefIn = c; bus.fifoPullOut = pl;
      @(posedge clk); #2;
      bus.PushIn = 0; bus.DataIn = '0; bus.PushCoef = 0; bus.CoefIn = '0; bus.fifoPullOut = 0;
   endtask

   task automatic checkResetValues(input string tag);
      check({tag, "_coef_valid"}, 256'(bus.coef_valid), 256'(0));
      check({tag, "_fifo_empty"}, 256'(bus.fifo_empty), 256'(1));
      check({tag, "_fifo_dout"},  256'(bus.fifo_dout),  256'(0));
      check({tag, "_coef_bank"},  256'(bus.coef_bank),  256'(0));
      check({tag, "_StopIn"},     256'(bus.StopIn),     256'(0));
      check({tag, "_ovf_err"},    256'(bus.ovf_err),    256'(0));
      check({tag, "_unf_err"},    256'(bus.unf_err),    256'(0));
   endtask

   logic [NC*DW-1:0] bank18;

   initial begin
      bus.PushIn = 0; bus.DataIn = '0; bus.PushCoef = 0; bus.CoefIn = '0; bus.fifoPullOut = 0;
      repeat (2) @(posedge clk);
      #2;
      checkResetValues("rst0");
      reset = 0;

      // 1: load coefficients 1..8, then one sample
      for (int k = 1; k <= NC; k++) begin
         drive(0, '0, 1, DW'(k), 0);
         if (k == NC - 1) check("t1_valid_before_last", 256'(bus.coef_valid), 256'(0));
      end
      check("t1_coef_valid", 256'(bus.coef_valid), 256'(1));
      check("t1_empty_pre",  256'(bus.fifo_empty), 256'(1));
      for (int k = 0; k < NC; k++) bank18[k*DW +: DW] = DW'(k + 1);
      check("t1_coef_bank", 256'(bus.coef_bank), 256'(bank18));
      drive(1, 32'hA, 0, '0, 0);
      check("t1_empty_post", 256'(bus.fifo_empty), 256'(0));
      check("t1_dout",       256'(bus.fifo_dout),  256'(32'hA));
      drive(0, '0, 0, '0, 1);
      check("t1_drained", 256'(bus.fifo_empty), 256'(1));

      // 2: fill to 16, StopIn timing, 17th push dropped
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 32'h100 + DW'(i), 0, '0, 0);
         if (i == 12) check("t2_stop_13", 256'(bus.StopIn), 256'(0));
         if (i == 13) check("t2_stop_14", 256'(bus.StopIn), 256'(1));
      end
      check("t2_ovf_before", 256'(bus.ovf_err), 256'(0));
      drive(1, 32'hDEAD, 0, '0, 0);
      check("t2_ovf_after", 256'(bus.ovf_err), 256'(1));
      check("t2_head",      256'(bus.fifo_dout), 256'(32'h100));

      // 3: push and pull together while full
      drive(1, 32'h200, 0, '0, 1);
      check("t3_head_adv", 256'(bus.fifo_dout), 256'(32'h101));
      check("t3_stop",     256'(bus.StopIn),    256'(1));
      for (int i = 0; i < DEPTH - 1; i++) drive(0, '0, 0, '0, 1);
      check("t3_tail_word", 256'(bus.fifo_dout), 256'(32'h200));
      drive(0, '0, 0, '0, 1);
      check("t3_empty", 256'(bus.fifo_empty), 256'(1));

      // 4: pull on empty with a simultaneous push
      check("t4_unf_before", 256'(bus.unf_err), 256'(0));
      drive(1, 32'h33, 0, '0, 1);
      check("t4_unf",   256'(bus.unf_err),    256'(1));
      check("t4_empty", 256'(bus.fifo_empty), 256'(0));
      check("t4_dout",  256'(bus.fifo_dout),  256'(32'h33));
      drive(0, '0, 0, '0, 1);

      // 5: coefficient reload while samples are queued
      for (int i = 0; i < 3; i++) drive(1, 32'h41 + DW'(i), 0, '0, 0);
      drive(0, '0, 1, 32'h55, 0);
      check("t5_valid_drop", 256'(bus.coef_valid), 256'(0));
      check("t5_empty_gate", 256'(bus.fifo_empty), 256'(1));
      check("t5_head_kept",  256'(bus.fifo_dout),  256'(32'h41));
      for (int k = 1; k < NC; k++) drive(0, '0, 1, 32'h55 + DW'(k), 0);
      check("t5_valid_back", 256'(bus.coef_valid), 256'(1));
      check("t5_empty_back", 256'(bus.fifo_empty), 256'(0));
      check("t5_head_back",  256'(bus.fifo_dout),  256'(32'h41));
      check("t5_coef0",      256'(bus.coef_bank[DW-1:0]), 256'(32'h55));

      // 6: asynchronous reset mid-stream with 5 queued
      drive(1, 32'h44, 0, '0, 0);
      drive(1, 32'h45, 0, '0, 0);
      #1 reset = 1;
      #1 checkResetValues("t6_async");
      repeat (2) @(posedge clk);
      #2 reset = 0;
      for (int k = 0; k < NC; k++) drive(0, '0, 1, 32'h61 + DW'(k), 0);
      drive(1, 32'h77, 0, '0, 0);
      check("t6_valid", 256'(bus.coef_valid), 256'(1));
      check("t6_empty", 256'(bus.fifo_empty), 256'(0));
      check("t6_dout",  256'(bus.fifo_dout),  256'(32'h77));
      drive(0, '0, 0, '0, 1);
      repeat (2) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
